// File: rtl/median_11_stream_ctrl.sv
// Streaming front end for the 11-input median sort network: keeps an 11-deep
// sliding window, triggers evaluations at a programmable stride and registers
// the network's min/median/max behind a valid/ready output.
module median_11_stream_ctrl #(
  parameter int W      = 32,
  parameter int STRIDE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  output logic [11*W-1:0] net_data,
  input  logic [11*W-1:0] net_sort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_median,
  output logic [W-1:0]    out_min,
  output logic [W-1:0]    out_max,
  output logic            out_last,
  output logic [15:0]     drop_cnt,
  output logic [3:0]      win_fill
);

  localparam int         N        = 11;
  localparam logic [3:0] FULL     = 4'd11;
  localparam logic [3:0] STRIDE_L = 4'(STRIDE);

  logic [W-1:0] win [N];
  logic [3:0]   stride_cnt;
  logic         eval;
  logic         eval_last;

  logic         accept;
  logic         capture;
  logic         emit;
  logic         emit_last;
  logic         frame_drop;
  logic [3:0]   fill_next;
  logic [3:0]   stride_inc;
  logic [3:0]   stride_next;

  // The network only reports min, median and max back to the consumer.
  logic sort_unused;
  assign sort_unused = ^{net_sort[6*W +: 4*W], net_sort[W +: 4*W]};

  for (genvar k = 0; k < N; k++) begin : g_net
    assign net_data[k*W +: W] = win[k];
  end

  // A pending evaluation pins the window until its result can be captured.
  assign in_ready   = !eval || !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign capture    = eval && (!out_valid || out_ready);
  assign stride_inc = stride_cnt + 4'd1;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else tree can leave a value held and infer a latch.
  always_comb begin
    fill_next   = (win_fill == FULL) ? FULL : win_fill + 4'd1;
    stride_next = stride_cnt;
    emit        = 1'b0;
    emit_last   = 1'b0;
    frame_drop  = 1'b0;

    if (win_fill == FULL) begin
      stride_next = stride_inc;
      if (stride_inc == STRIDE_L) begin
        emit        = 1'b1;
        stride_next = '0;
      end
    end else if (fill_next == FULL) begin
      emit        = 1'b1;
      stride_next = '0;
    end

    // Frame end: a full window always reports, a short one is discarded.
    if (in_last) begin
      stride_next = '0;
      if (fill_next == FULL) begin
        emit      = 1'b1;
        emit_last = 1'b1;
      end else begin
        frame_drop = 1'b1;
      end
    end
  end

  // NOTE: the window is reset even though it is storage, because net_data
  // exposes it directly and downstream sees defined values out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) win[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < N-1; k++) win[k] <= win[k+1];
      win[N-1] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_fill   <= '0;
      stride_cnt <= '0;
      drop_cnt   <= '0;
      eval       <= 1'b0;
      eval_last  <= 1'b0;
    end else begin
      if (accept) begin
        win_fill   <= in_last ? 4'd0 : fill_next;
        stride_cnt <= stride_next;
        if (frame_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end

      if (accept && emit) begin
        eval      <= 1'b1;
        eval_last <= emit_last;
      end else if (capture) begin
        eval <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_median <= '0;
      out_min    <= '0;
      out_max    <= '0;
      out_last   <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_min    <= net_sort[0 +: W];
      out_median <= net_sort[5*W +: W];
      out_max    <= net_sort[10*W +: W];
      out_last   <= eval_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_11_stream_ctrl.sv
// Directed bench for median_11_stream_ctrl: a behavioural sorter stands in for
// the network; STRIDE=1 and STRIDE=2 instances share the input stimulus.
module tb_median_11_stream_ctrl;

  localparam int W = 32;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_last, out_ready;
  logic [W-1:0] in_data;

  logic            ir_a, ov_a, last_a, ir_b, ov_b, last_b;
  logic [11*W-1:0] nd_a, ns_a, nd_b, ns_b;
  logic [W-1:0]    med_a, min_a, max_a, med_b, min_b, max_b;
  logic [15:0]     drop_a, drop_b;
  logic [3:0]      fill_a, fill_b;

  function automatic logic [11*W-1:0] sort11(input logic [11*W-1:0] v);
    logic [W-1:0] a [11];
    logic [W-1:0] t;
    logic [11*W-1:0] r;
    for (int i = 0; i < 11; i++) a[i] = v[i*W +: W];
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 11; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  assign ns_a = sort11(nd_a);
  assign ns_b = sort11(nd_b);

  median_11_stream_ctrl #(.W(W), .STRIDE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .in_last(in_last), .net_data(nd_a), .net_sort(ns_a), .out_valid(ov_a),
    .out_ready(out_ready), .out_median(med_a), .out_min(min_a), .out_max(max_a),
    .out_last(last_a), .drop_cnt(drop_a), .win_fill(fill_a));

  median_11_stream_ctrl #(.W(W), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
    .in_last(in_last), .net_data(nd_b), .net_sort(ns_b), .out_valid(ov_b),
    .out_ready(out_ready), .out_median(med_b), .out_min(min_b), .out_max(max_b),
    .out_last(last_b), .drop_cnt(drop_b), .win_fill(fill_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One row = inputs held for one clock, then expected state just after the edge.
  typedef struct {
    bit          rst, iv, il, ordy, sel;
    logic [31:0] d;
    bit          e_ov, e_ir, cd, e_last;
    logic [3:0]  e_fill;
    logic [15:0] e_drop;
    logic [31:0] e_min, e_med, e_max;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit r, bit iv, logic [31:0] d, bit il, bit ordy, bit sel,
                              bit ov, bit ir, logic [3:0] fill, logic [15:0] drop,
                              bit cd, logic [31:0] mn, logic [31:0] md, logic [31:0] mx,
                              bit lst);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.il = il; v.ordy = ordy; v.sel = sel;
    v.e_ov = ov; v.e_ir = ir; v.e_fill = fill; v.e_drop = drop;
    v.cd = cd; v.e_min = mn; v.e_med = md; v.e_max = mx; v.e_last = lst;
    return v;
  endfunction

  task automatic add_reset(input bit ordy, input bit sel);
    tbl.push_back(mk(1, 0, 0, 0, ordy, sel, 0, 1, 0, 0, 1, 0, 0, 0, 0));
  endtask

  // Frame 10,20,..,110 with last on 110, then the result cycle and a drain cycle.
  task automatic add_fill_frame();
    for (int i = 1; i <= 11; i++)
      tbl.push_back(mk(0, 1, 32'(10*i), i == 11, 1, 0, 0, 1,
                       (i == 11) ? 4'd0 : 4'(i), 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 10, 60, 110, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    vec_t v;
    logic a_ov, a_ir, a_last;
    logic [3:0] a_fill;
    logic [15:0] a_drop;
    logic [31:0] a_min, a_med, a_max;
    int idx, stall, n_res;
    bit started, saw_block, acc;
    logic [31:0] res_med [3];
    logic res_last [3];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

    // Fill to first result, STRIDE=1.
    add_reset(1, 0);
    add_fill_frame();

    // Sliding window on the STRIDE=2 instance: results after 11, 13, 15.
    add_reset(1, 1);
    for (int i = 1; i <= 15; i++) begin
      bit ov;
      ov = (i == 12) || (i == 14);
      tbl.push_back(mk(0, 1, 32'(i), 0, 1, 1, ov, 1, (i < 11) ? 4'(i) : 4'd11, 0,
                       ov, 32'(i-11), 32'(i-6), 32'(i-1), 0));
    end
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 11, 0, 1, 5, 10, 15, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 11, 0, 0, 0, 0, 0, 0));

    // Short frame dropped, then frame 0..10, then duplicates and extremes.
    add_reset(1, 0);
    for (int i = 1; i <= 7; i++)
      tbl.push_back(mk(0, 1, 32'(100+i), i == 7, 1, 0, 0, 1,
                       (i == 7) ? 4'd0 : 4'(i), (i == 7) ? 16'd1 : 16'd0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 11; i++)
      tbl.push_back(mk(0, 1, 32'(i-1), i == 11, 1, 0, 0, 1,
                       (i == 11) ? 4'd0 : 4'(i), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 5, 10, 1));
    for (int i = 1; i <= 11; i++)
      tbl.push_back(mk(0, 1, ONES, i == 11, 1, 0, 0, 1,
                       (i == 11) ? 4'd0 : 4'(i), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 1, ONES, ONES, ONES, 1));
    for (int i = 1; i <= 11; i++)
      tbl.push_back(mk(0, 1, (i <= 6) ? 32'd0 : ONES, i == 11, 1, 0, 0, 1,
                       (i == 11) ? 4'd0 : 4'(i), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, ONES, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));

    // Reset mid-frame with a held result and a nonzero drop count.
    add_reset(1, 0);
    for (int i = 1; i <= 3; i++)
      tbl.push_back(mk(0, 1, 32'(4+i), i == 3, 1, 0, 0, 1,
                       (i == 3) ? 4'd0 : 4'(i), (i == 3) ? 16'd1 : 16'd0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 11; i++)
      tbl.push_back(mk(0, 1, 32'(i), i == 11, 0, 0, 0, 1,
                       (i == 11) ? 4'd0 : 4'(i), 1, 0, 0, 0, 0, 0));
    for (int j = 1; j <= 9; j++)
      tbl.push_back(mk(0, 1, 32'(50+j), 0, 0, 0, 1, 1, 4'(j), 1, 1, 1, 6, 11, 1));
    add_reset(0, 0);
    add_fill_frame();

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst = v.rst; in_valid = v.iv; in_data = v.d; in_last = v.il; out_ready = v.ordy;
      @(posedge clk); #1;
      if (v.sel) begin
        a_ov = ov_b; a_ir = ir_b; a_fill = fill_b; a_drop = drop_b;
        a_min = min_b; a_med = med_b; a_max = max_b; a_last = last_b;
      end else begin
        a_ov = ov_a; a_ir = ir_a; a_fill = fill_a; a_drop = drop_a;
        a_min = min_a; a_med = med_a; a_max = max_a; a_last = last_a;
      end
      check($sformatf("row%0d out_valid", i), 32'(a_ov), 32'(v.e_ov));
      check($sformatf("row%0d in_ready", i), 32'(a_ir), 32'(v.e_ir));
      check($sformatf("row%0d win_fill", i), 32'(a_fill), 32'(v.e_fill));
      check($sformatf("row%0d drop_cnt", i), 32'(a_drop), 32'(v.e_drop));
      if (v.cd) begin
        check($sformatf("row%0d out_min", i), a_min, v.e_min);
        check($sformatf("row%0d out_median", i), a_med, v.e_med);
        check($sformatf("row%0d out_max", i), a_max, v.e_max);
        check($sformatf("row%0d out_last", i), 32'(a_last), 32'(v.e_last));
      end
    end

    // Backpressure: 13 samples, consumer stalls 5 cycles once the first result shows.
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idx = 1; stall = 0; n_res = 0; started = 0; saw_block = 0;
    for (int cyc = 0; cyc < 200 && n_res < 3; cyc++) begin
      in_valid  = (idx <= 13);
      in_data   = 32'(idx);
      in_last   = (idx == 13);
      out_ready = (stall == 0);
      @(negedge clk);
      acc = in_valid && ir_a;
      if (in_valid && !ir_a) saw_block = 1;
      if (ov_a && out_ready) begin
        res_med[n_res]  = med_a;
        res_last[n_res] = last_a;
        n_res++;
      end
      if (ov_a && !out_ready) check("bp held median", med_a, 6);
      @(posedge clk); #1;
      if (acc) idx++;
      if (stall > 0) stall--;
      else if (!started && ov_a) begin started = 1; stall = 5; end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    check("bp result count", 32'(n_res), 3);
    check("bp in_ready dropped", 32'(saw_block), 1);
    check("bp all samples accepted", 32'(idx), 14);
    if (n_res == 3) begin
      check("bp median 0", res_med[0], 6);
      check("bp median 1", res_med[1], 7);
      check("bp median 2", res_med[2], 8);
      check("bp last 0", 32'(res_last[0]), 0);
      check("bp last 2", 32'(res_last[2]), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_11_stream_ctrl.md
Name: median_11_stream_ctrl

Overview:
Streaming controller for the 11-input median sorting network. It accepts a scalar sample stream over a valid/ready handshake and keeps an 11-deep sliding window, which it presents to the combinational sort network. At a programmable stride it captures the network's median, min and max into a registered output with valid/ready backpressure. Frames are delimited by in_last; a window that is not full at frame end is dropped and counted.

Parameters:
W, 32, sample width in bits (unsigned compare, matching the network's <= ordering)
STRIDE, 1, accepted samples between emitted results once the window is full; legal range 1..11

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  sample offered
in_ready  out  1  controller can accept a sample
in_data  in  W  sample value
in_last  in  1  sample is the final one of its frame
net_data  out  11*W  window to sort network; slot k at [k*W +: W], slot 0 oldest, slot 10 newest
net_sort  in  11*W  sorted network result, same packing, ascending
out_valid  out  1  result held
out_ready  in  1  consumer accepts result
out_median  out  W  net_sort slot 5
out_min  out  W  net_sort slot 0
out_max  out  W  net_sort slot 10
out_last  out  1  result closes a frame
drop_cnt  out  16  frames ended with fewer than 11 samples, saturating
win_fill  out  4  samples currently in window, 0..11

Behaviour:
- One clock domain, clk; rst is synchronous and active-high.
- Reset: window registers, win_fill, stride counter, eval flag, out_valid, out_median, out_min, out_max, out_last and drop_cnt all 0.
- Accept: a sample is accepted when in_valid && in_ready at a clk edge.
- Window update on accept: shift down one slot (slot k gets slot k+1), slot 10 gets in_data, win_fill increments and saturates at 11.
- net_data is driven directly from the window registers, with no combinational path from in_data.
- Emit decision, evaluated on accept using the post-accept state:
  - win_fill reaches 11 for the first time in the frame → emit, stride_cnt cleared to 0.
  - Window already full → stride_cnt increments; when it reaches STRIDE → emit, stride_cnt cleared.
  - in_last with post-accept win_fill == 11 → always emit, with the eval last flag set.
  - in_last with post-accept win_fill < 11 → no emit; drop_cnt increments (holds at 0xFFFF).
- Emit sets the eval flag at that edge. The window now reflects the triggering sample, and net_sort settles within the following cycle.
- Capture: at the next edge where eval is set and (!out_valid || out_ready):
  - out_min, out_median and out_max load from net_sort;
  - out_last loads from the eval last flag;
  - out_valid becomes 1 and eval clears.
- Latency: out_valid rises at the edge after the accepting edge, i.e. 1 cycle from acceptance to result, provided the output register is free.
- in_ready = !eval || !out_valid || out_ready. The window never shifts while a pending eval still needs the current net_data. Full throughput (1 sample per cycle) is sustained when out_ready = 1.
- Output handshake: out_valid && out_ready with no new capture → out_valid clears. Capture and consume on the same edge → out_valid stays 1 with new data.
- Output stability: while out_valid && !out_ready, all out_* hold stable.
- End of frame: on accepting an in_last sample, win_fill and stride_cnt clear at the same edge. Window contents are kept, with no clearing required. The next sample starts a new frame.
- Simultaneous case: the in_last sample that triggers an emit is still captured from the full window, since the eval data comes from the window registers, not from win_fill.
- Reset mid-operation: any pending eval and held result are discarded, and out_valid = 0 in the cycle after rst.

Test Plan:
- Fill to first result: STRIDE=1, out_ready=1, feed 10,20,…,110 back-to-back, last on 110 → exactly one result one cycle after 110 is accepted: min=10, median=60, max=110, out_last=1, drop_cnt=0.
- Sliding stride: STRIDE=2, feed values 1..15 with no in_last → results after samples 11, 13, 15 with medians 6, 8, 10; win_fill stays at 11.
- Backpressure: STRIDE=1, 13 samples, out_ready=0 for 5 cycles after the first result → in_ready drops while eval is set and out_valid is held; the first result holds unchanged; no sample is lost; after release, medians come out in order with no duplicates.
- Short frame: 7 samples, last on the 7th → no out_valid, drop_cnt=1, win_fill=0. The next 11-sample frame 0..10 → median 5.
- Duplicates/extremes: eleven 0xFFFFFFFF values, then a frame of six 0s and five 0xFFFFFFFF values → medians 0xFFFFFFFF then 0, min and max correct.
- Reset mid-frame: assert rst after 9 samples, with a result held and out_ready=0 → out_valid=0, win_fill=0 and drop_cnt=0 one cycle later; the subsequent full frame behaves as in the fill-to-first-result scenario.
